// File: rtl/regfile_scoreboard.sv
// Multi-port general-purpose register file with a per-register busy scoreboard.
// A clear sequencer zeroes every entry after reset before the file reports ready.
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_wen,
  input  logic [ADDR_WIDTH-1:0]            i_waddr,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic                             i_issue_valid,
  input  logic [ADDR_WIDTH-1:0]            i_issue_rd,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] i_raddr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] o_rdata,
  output logic [NUM_RPORTS-1:0]            o_rbusy,
  output logic                             o_ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   rf_q [DEPTH];

  logic                    rf_we;
  logic [ADDR_WIDTH-1:0]   rf_waddr;
  logic [DATA_WIDTH-1:0]   rf_wdata;
  logic                    ready;

  assign ready   = (state_q == READY);
  assign o_ready = ready;

  // Clear sequencer and single write-port arbitration between clear and writeback.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    unique case (state_q)
      CLEAR: begin
        rf_we     = 1'b1;
        rf_waddr  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d = READY;
        end
      end
      READY: begin
        if (i_wen && (i_waddr != '0)) begin
          rf_we    = 1'b1;
          rf_waddr = i_waddr;
          rf_wdata = i_wdata;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Issue is applied after writeback so a new producer supersedes the old one.
  always_comb begin
    busy_d = busy_q;
    if (ready) begin
      if (i_wen) begin
        busy_d[i_waddr] = 1'b0;
      end
      if (i_issue_valid) begin
        busy_d[i_issue_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (i_reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // NOTE: the storage array has no reset term; the clear sequencer zeroes it
  // one entry per cycle, which keeps the array a plain enable-only register bank.
  always_ff @(posedge i_clock) begin
    if (rf_we && !i_reset) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rport
    logic [ADDR_WIDTH-1:0] ra;
    logic                  fwd;

    assign ra  = i_raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign fwd = (BYPASS != 0) && ready && i_wen && (i_waddr == ra);

    assign o_rdata[k*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 :
                                                 fwd        ? i_wdata :
                                                              rf_q[ra];
    assign o_rbusy[k] = (ra != '0) && !fwd && busy_q[ra];
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file for the pipelined core, with N read ports, one write port and optional write-to-read bypass. Holds a per-register busy scoreboard: set at issue, cleared at writeback, so decode can detect RAW hazards. After reset, a sequential clear FSM zeroes every entry. Sits between decode/issue (reads, issue marks) and writeback (writes).

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 32, register data width.
NUM_RPORTS, 2, number of read ports (>=1).
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = registered read data only.

Ports:
i_clock  input  1  clock; all state updates on the rising edge.
i_reset  input  1  synchronous reset, active-high.
i_wen  input  1  writeback write enable.
i_waddr  input  ADDR_WIDTH  writeback destination index.
i_wdata  input  DATA_WIDTH  writeback data.
i_issue_valid  input  1  instruction issued with a destination register.
i_issue_rd  input  ADDR_WIDTH  destination index to mark busy.
i_raddr  input  NUM_RPORTS*ADDR_WIDTH  read indices; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
o_rdata  output  NUM_RPORTS*DATA_WIDTH  read data; port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
o_rbusy  output  NUM_RPORTS  per-port busy flag (a pending writer exists).
o_ready  output  1  1 = clear finished; register file usable.

Behaviour:
- Reset and clear FSM: the FSM has two states, CLEAR and READY. With i_reset high: state <= CLEAR, clear counter <= 0, all busy bits <= 0. In CLEAR, each cycle writes 0 to rf[counter] and increments the counter. When counter == 2**ADDR_WIDTH-1, that entry is written and state moves to READY. Clear takes 2**ADDR_WIDTH cycles after reset deasserts.
- o_ready is 0 during reset and CLEAR, and 1 in READY. It is registered (derived from state).
- An i_reset assertion mid-clear restarts the clear from index 0. An i_reset assertion in READY returns to CLEAR.
- During CLEAR, i_wen and i_issue_valid are ignored. Outputs then follow the read rules below and report 0 or partially cleared data; consumers must gate reads on o_ready.
- Index 0: reads always return 0 and o_rbusy=0. Writes to index 0 are discarded. Issues to index 0 set no busy bit.
- Write: when READY and i_wen=1 and i_waddr!=0, rf[i_waddr] <= i_wdata at the clock edge.
- Scoreboard update, per index r, when READY, at the clock edge:
  - If an issue targets r, busy[r] <= 1. Issue wins over a simultaneous writeback to the same r, because the new producer supersedes the old one.
  - Else, if a writeback targets r, busy[r] <= 0.
  - Else, busy[r] holds.
  - A writeback to a non-busy register still writes data; busy stays 0.
- Read (combinational, every port independent, any port may alias any other):
  - Read index 0: o_rdata = 0 and o_rbusy = 0.
  - BYPASS=1 and i_wen=1 and i_waddr == raddr_k (nonzero) and READY: o_rdata_k = i_wdata and o_rbusy_k = 0.
  - Otherwise: o_rdata_k = rf[raddr_k] and o_rbusy_k = busy[raddr_k].
  - With BYPASS=0, a same-cycle write is not visible. The new value appears the cycle after the write edge, and busy clears the cycle after as well.
- A same-cycle issue is never reflected in o_rbusy. Busy becomes visible the cycle after the issue edge.
- Data width is exactly DATA_WIDTH; there is no extension or truncation.

Test Plan:
1. Reset: assert i_reset for 2 cycles, then release. Required: o_ready=0 for exactly 32 cycles (ADDR_WIDTH=5), then 1. Reading every index then returns 0x00000000 with busy=0.
2. Write 0xDEADBEEF to x5 and read x5 on both ports in the same cycle. Required: BYPASS=1 returns 0xDEADBEEF in the same cycle. BYPASS=0 returns the old value (0) that cycle and 0xDEADBEEF on the next cycle.
3. Issue rd=7, then read x7 next cycle. Required: o_rbusy=1. Writeback x7=0x12345678. Required: same-cycle read gives busy=0 with data 0x12345678 (BYPASS=1); next cycle gives busy=0 with data 0x12345678.
4. Same cycle: issue rd=3 and writeback x3=0xA5A5A5A5 (x3 previously busy). Required: next cycle x3 reads 0xA5A5A5A5 with busy=1.
5. Issue rd=0 and write x0=0xFFFFFFFF. Required: x0 reads 0 with busy=0 on all ports in all cycles.
6. Write x1=1 while READY, then reset mid-clear at counter=10 and hold reset low afterwards. Required: clear restarts, o_ready rises 32 cycles after the second release, x1 reads 0, and writes attempted during CLEAR have no effect.
